// File: rtl/core_general.sv
// core_general: shared core widths, data-side address map and bus helpers
package core_general;
    localparam int XLEN = 32;
    localparam int AWIDTH = 32;
    localparam logic [AWIDTH-1:0] GPIO_IN_A = 32'h8000_0000;
    localparam logic [AWIDTH-1:0] GPIO_OUT_A = 32'h8000_0004;
    localparam logic [AWIDTH-1:0] MTIME_LO_A = 32'h8000_1000;
    localparam logic [AWIDTH-1:0] MTIME_HI_A = 32'h8000_1004;
    localparam logic [AWIDTH-1:0] MTIMECMP_LO_A = 32'h8000_1008;
    localparam logic [AWIDTH-1:0] MTIMECMP_HI_A = 32'h8000_100C;
    localparam logic [AWIDTH-1:0] VGA_COLOR_A = 32'h8000_2000;
    localparam logic [9:0] H_VIS = 10'd640;
    localparam logic [9:0] H_SYNC_S = 10'd656;
    localparam logic [9:0] H_SYNC_E = 10'd751;
    localparam logic [9:0] H_MAX = 10'd799;
    localparam logic [9:0] V_VIS = 10'd480;
    localparam logic [9:0] V_SYNC_S = 10'd490;
    localparam logic [9:0] V_SYNC_E = 10'd491;
    localparam logic [9:0] V_MAX = 10'd524;
    typedef enum logic [3:0] {
        T_NONE, T_RAM, T_GPIO_IN, T_GPIO_OUT, T_MTIME_LO, T_MTIME_HI, T_CMP_LO, T_CMP_HI, T_VGA
    } target_e;
    // takes the word address; byte offset bits never take part in decode
    function automatic target_e decode(input logic [AWIDTH-1:2] a);
        return !a[AWIDTH-1] ? T_RAM :
               a == GPIO_IN_A[AWIDTH-1:2] ? T_GPIO_IN :
               a == GPIO_OUT_A[AWIDTH-1:2] ? T_GPIO_OUT :
               a == MTIME_LO_A[AWIDTH-1:2] ? T_MTIME_LO :
               a == MTIME_HI_A[AWIDTH-1:2] ? T_MTIME_HI :
               a == MTIMECMP_LO_A[AWIDTH-1:2] ? T_CMP_LO :
               a == MTIMECMP_HI_A[AWIDTH-1:2] ? T_CMP_HI :
               a == VGA_COLOR_A[AWIDTH-1:2] ? T_VGA : T_NONE;
    endfunction
    function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old, input logic [XLEN-1:0] d, input logic [3:0] we);
        for (int i = 0; i < 4; i++) merge[8*i +: 8] = we[i] ? d[8*i +: 8] : old[8*i +: 8];
    endfunction
endpackage

// File: rtl/local_bus_if.sv
// local_bus_if: core data-port bus, word access with byte-lane write enables
interface local_bus_if;
    import core_general::*;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] qin;
    logic [XLEN-1:0] qout;
    logic [3:0] we;
    modport master(output addr, qin, we, input qout);
    modport slave(input addr, qin, we, output qout);
endinterface

// File: rtl/data_memory.sv
// data_memory: data RAM wrapper holding the U_ram instance
module data_memory
    import core_general::*;
#(
    parameter int AW = 12
) (
    input  logic            clk,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [3:0]      we,
    output logic [XLEN-1:0] rdata
);
    data_memory_ram #(.AW(AW)) U_ram (.clk(clk), .a(addr), .d(wdata), .we(we), .q(rdata));
endmodule

// File: rtl/data_memory_ram.sv
// data_memory_ram: byte-enabled read-first synchronous RAM with preloadable array RAM
module data_memory_ram
    import core_general::*;
#(
    parameter int AW = 12
) (
    input  logic            clk,
    input  logic [AW-1:0]   a,
    input  logic [XLEN-1:0] d,
    input  logic [3:0]      we,
    output logic [XLEN-1:0] q
);
    logic [XLEN-1:0] RAM [0:2**AW-1];
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) if (we[i]) RAM[a][8*i +: 8] <= d[8*i +: 8];
        q <= RAM[a];
    end
endmodule

// File: rtl/local_bus.sv
// local_bus: data-side slave decoding RAM, GPIO, machine timer and 640x480 VGA generator
module local_bus
    import core_general::*;
#(
    parameter int DMEM_AW = 12,
    parameter int PIX_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    local_bus_if.slave  bus,
    input  logic [12:0] gpio_pin_in,
    output logic [7:0]  gpio_pin_out,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  rdata,
    output logic [3:0]  gdata,
    output logic [3:0]  bdata,
    output logic        int_timer
);
    localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
    target_e sel;
    logic ram_sel_q, wr, pix_en, unused_ok;
    logic [XLEN-1:0] ram_q, reg_q, cur, wd;
    logic [12:0] sync1, sync2;
    logic [7:0] gpio_out;
    logic [63:0] mtime, mtimecmp, mtime_inc;
    logic [11:0] color;
    logic [DW-1:0] div;
    logic [9:0] h, v;
    assign unused_ok = ^bus.addr[1:0];
    assign sel = decode(bus.addr[XLEN-1:2]);
    assign wr = |bus.we;
    assign mtime_inc = mtime + 64'd1;
    assign gpio_pin_out = gpio_out;
    assign pix_en = div == DW'(PIX_DIV - 1);
    always_comb begin
        cur = sel == T_GPIO_IN ? XLEN'(sync2) :
              sel == T_GPIO_OUT ? XLEN'(gpio_out) :
              sel == T_MTIME_LO ? mtime[31:0] :
              sel == T_MTIME_HI ? mtime[63:32] :
              sel == T_CMP_LO ? mtimecmp[31:0] :
              sel == T_CMP_HI ? mtimecmp[63:32] :
              sel == T_VGA ? XLEN'(color) : '0;
        wd = merge(cur, bus.qin, bus.we);
    end
    data_memory #(.AW(DMEM_AW)) U_data_memory (
        .clk(clk), .addr(bus.addr[DMEM_AW+1:2]), .wdata(bus.qin),
        .we(sel == T_RAM ? bus.we : 4'd0), .rdata(ram_q)
    );
    assign bus.qout = ram_sel_q ? ram_q : reg_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_sel_q <= 1'b0;
            reg_q <= '0;
            sync1 <= '0;
            sync2 <= '0;
            gpio_out <= '0;
            mtime <= '0;
            mtimecmp <= '1;
            int_timer <= 1'b0;
            color <= '0;
        end else begin
            ram_sel_q <= sel == T_RAM;
            reg_q <= cur;
            sync1 <= gpio_pin_in;
            sync2 <= sync1;
            int_timer <= mtime >= mtimecmp;
            if (wr && sel == T_GPIO_OUT) gpio_out <= wd[7:0];
            if (wr && sel == T_VGA) color <= wd[11:0];
            if (wr && sel == T_CMP_LO) mtimecmp[31:0] <= wd;
            if (wr && sel == T_CMP_HI) mtimecmp[63:32] <= wd;
            // a bus write replaces its half; the other half still advances
            mtime <= !wr ? mtime_inc :
                     sel == T_MTIME_LO ? {mtime_inc[63:32], wd} :
                     sel == T_MTIME_HI ? {wd, mtime_inc[31:0]} : mtime_inc;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            h <= '0;
            v <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            {rdata, gdata, bdata} <= '0;
        end else begin
            div <= pix_en ? '0 : div + DW'(1);
            if (pix_en) h <= h == H_MAX ? '0 : h + 10'd1;
            if (pix_en && h == H_MAX) v <= v == V_MAX ? '0 : v + 10'd1;
            hsync <= !(h >= H_SYNC_S && h <= H_SYNC_E);
            vsync <= !(v >= V_SYNC_S && v <= V_SYNC_E);
            {rdata, gdata, bdata} <= (h < H_VIS && v < V_VIS) ? color : 12'd0;
        end
    end
endmodule

// File: tb/tb_local_bus.sv
// tb_local_bus: directed self-checking bench for the local_bus data-side slave
module tb_local_bus;
    import core_general::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [12:0] gpio_pin_in = '0;
    logic [7:0] gpio_pin_out;
    logic hsync, vsync, int_timer;
    logic [3:0] rdata, gdata, bdata;
    int total = 0;
    int bad = 0;
    local_bus_if bus();
    local_bus dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .gpio_pin_in(gpio_pin_in), .gpio_pin_out(gpio_pin_out),
        .hsync(hsync), .vsync(vsync), .rdata(rdata), .gdata(gdata), .bdata(bdata), .int_timer(int_timer)
    );
    always #5 clk = ~clk;

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        @(negedge clk);
        bus.addr = a;
        bus.qin = d;
        bus.we = w;
        @(posedge clk);
        #1 bus.we = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] q);
        @(negedge clk);
        bus.addr = a;
        bus.we = 4'h0;
        @(posedge clk);
        @(negedge clk);
        q = bus.qout;
    endtask

    task automatic test_reset();
        logic [31:0] q;
        bus.addr = '0;
        bus.qin = '0;
        bus.we = '0;
        repeat (3) @(negedge clk);
        total++; if (bus.qout !== 32'h0) begin bad++; $display("FAIL reset_qout got=%h exp=%h", bus.qout, 32'h0); end
        total++; if (gpio_pin_out !== 8'h00) begin bad++; $display("FAIL reset_gpio got=%h exp=%h", gpio_pin_out, 8'h00); end
        total++; if ({hsync, vsync} !== 2'b11) begin bad++; $display("FAIL reset_sync got=%b exp=%b", {hsync, vsync}, 2'b11); end
        total++; if ({rdata, gdata, bdata} !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h exp=%h", {rdata, gdata, bdata}, 12'h000); end
        total++; if (int_timer !== 1'b0) begin bad++; $display("FAIL reset_int got=%b exp=%b", int_timer, 1'b0); end
        rst_n = 1'b1;
        rd(MTIMECMP_HI_A, q);
        total++; if (q !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_mtimecmp got=%h exp=%h", q, 32'hFFFF_FFFF); end
    endtask

    task automatic test_ram();
        logic [31:0] q;
        wr(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        rd(32'h0000_0010, q);
        total++; if (q !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_full got=%h exp=%h", q, 32'hDEAD_BEEF); end
        wr(32'h0000_0010, 32'h0000_00AA, 4'h1);
        rd(32'h0000_0010, q);
        total++; if (q !== 32'hDEAD_BEAA) begin bad++; $display("FAIL ram_lane0 got=%h exp=%h", q, 32'hDEAD_BEAA); end
        wr(32'h0000_0010, 32'h1122_3344, 4'hF);
        @(negedge clk);
        q = bus.qout;
        total++; if (q !== 32'hDEAD_BEAA) begin bad++; $display("FAIL ram_read_first got=%h exp=%h", q, 32'hDEAD_BEAA); end
        rd(32'h0000_0010, q);
        total++; if (q !== 32'h1122_3344) begin bad++; $display("FAIL ram_rewrite got=%h exp=%h", q, 32'h1122_3344); end
        wr(32'h0000_0012, 32'hAABB_0000, 4'hC);
        rd(32'h0000_0010, q);
        total++; if (q !== 32'hAABB_3344) begin bad++; $display("FAIL ram_upper_lanes got=%h exp=%h", q, 32'hAABB_3344); end
        wr(32'h0000_0014, 32'h1234_5678, 4'hF);
        rd(32'h0000_4014, q);
        total++; if (q !== 32'h1234_5678) begin bad++; $display("FAIL ram_alias got=%h exp=%h", q, 32'h1234_5678); end
        rd(32'h0000_0010, q);
        total++; if (q !== 32'hAABB_3344) begin bad++; $display("FAIL ram_neighbour got=%h exp=%h", q, 32'hAABB_3344); end
    endtask

    task automatic test_gpio();
        logic [31:0] q;
        wr(GPIO_OUT_A, 32'hFFFF_FF5A, 4'hF);
        total++; if (gpio_pin_out !== 8'h5A) begin bad++; $display("FAIL gpio_out_pin got=%h exp=%h", gpio_pin_out, 8'h5A); end
        rd(GPIO_OUT_A, q);
        total++; if (q !== 32'h0000_005A) begin bad++; $display("FAIL gpio_out_read got=%h exp=%h", q, 32'h0000_005A); end
        @(negedge clk);
        gpio_pin_in = 13'h1ABC;
        rd(GPIO_IN_A, q);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL gpio_in_sync_delay got=%h exp=%h", q, 32'h0); end
        rd(GPIO_IN_A, q);
        total++; if (q !== 32'h0000_1ABC) begin bad++; $display("FAIL gpio_in got=%h exp=%h", q, 32'h0000_1ABC); end
        wr(32'h8000_3000, 32'hFFFF_FFFF, 4'hF);
        rd(32'h8000_3000, q);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL unmapped got=%h exp=%h", q, 32'h0); end
        rd(32'h8000_1010, q);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL unmapped_timer got=%h exp=%h", q, 32'h0); end
    endtask

    task automatic test_timer();
        wr(MTIME_HI_A, 32'h0, 4'hF);
        wr(MTIME_LO_A, 32'h0, 4'hF);
        wr(MTIMECMP_HI_A, 32'h0, 4'hF);
        wr(MTIMECMP_LO_A, 32'd100, 4'hF);
        // mtime after edge A+k is k; the compare sees 100 at edge A+101
        repeat (98) @(posedge clk);
        #1;
        total++; if (int_timer !== 1'b0) begin bad++; $display("FAIL timer_before got=%b exp=%b", int_timer, 1'b0); end
        @(posedge clk);
        #1;
        total++; if (int_timer !== 1'b1) begin bad++; $display("FAIL timer_rise got=%b exp=%b", int_timer, 1'b1); end
        wr(MTIMECMP_LO_A, 32'hFFFF_FFFF, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        total++; if (int_timer !== 1'b0) begin bad++; $display("FAIL timer_clear got=%b exp=%b", int_timer, 1'b0); end
    endtask

    task automatic test_mtime_carry();
        logic [31:0] q;
        wr(MTIME_LO_A, 32'hFFFF_FFFE, 4'hF);
        wr(MTIME_HI_A, 32'h0, 4'hF);
        rd(MTIME_HI_A, q);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL mtime_hi_before got=%h exp=%h", q, 32'h0); end
        rd(MTIME_HI_A, q);
        total++; if (q !== 32'h1) begin bad++; $display("FAIL mtime_carry got=%h exp=%h", q, 32'h1); end
    endtask

    task automatic test_vga();
        logic [31:0] q;
        int n;
        logic vs_ok, blank_ok, hs_ok;
        vs_ok = 1'b1;
        blank_ok = 1'b1;
        hs_ok = 1'b1;
        wr(VGA_COLOR_A, 32'h0000_0F0F, 4'hF);
        rd(VGA_COLOR_A, q);
        total++; if (q !== 32'h0000_0F0F) begin bad++; $display("FAIL vga_color_read got=%h exp=%h", q, 32'h0000_0F0F); end
        n = 0;
        while ({rdata, gdata, bdata} !== 12'hF0F && n < 4000) begin @(negedge clk); n++; end
        total++; if (n >= 4000) begin bad++; $display("FAIL vga_visible_timeout got=%0d exp=<4000", n); end
        n = 0;
        while ({rdata, gdata, bdata} === 12'hF0F && n < 4000) begin @(negedge clk); n++; end
        total++; if ({rdata, gdata, bdata} !== 12'h000) begin bad++; $display("FAIL vga_blank_rgb got=%h exp=%h", {rdata, gdata, bdata}, 12'h000); end
        n = 0;
        while (hsync === 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
            vs_ok &= vsync === 1'b1;
            blank_ok &= {rdata, gdata, bdata} === 12'h000;
        end
        total++; if (n !== 64) begin bad++; $display("FAIL vga_front_porch got=%0d exp=%0d", n, 64); end
        n = 0;
        while (hsync === 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
            vs_ok &= vsync === 1'b1;
            blank_ok &= {rdata, gdata, bdata} === 12'h000;
        end
        total++; if (n !== 384) begin bad++; $display("FAIL vga_hsync_width got=%0d exp=%0d", n, 384); end
        n = 0;
        while ({rdata, gdata, bdata} === 12'h000 && n < 4000) begin
            @(negedge clk);
            n++;
            vs_ok &= vsync === 1'b1;
            hs_ok &= hsync === 1'b1;
        end
        total++; if (n !== 192) begin bad++; $display("FAIL vga_back_porch got=%0d exp=%0d", n, 192); end
        n = 0;
        while ({rdata, gdata, bdata} === 12'hF0F && n < 4000) begin
            @(negedge clk);
            n++;
            vs_ok &= vsync === 1'b1;
            hs_ok &= hsync === 1'b1;
        end
        total++; if (n !== 2560) begin bad++; $display("FAIL vga_visible_width got=%0d exp=%0d", n, 2560); end
        total++; if ({rdata, gdata, bdata} !== 12'h000) begin bad++; $display("FAIL vga_visible_end got=%h exp=%h", {rdata, gdata, bdata}, 12'h000); end
        total++; if (!blank_ok) begin bad++; $display("FAIL vga_blank_during_sync got=%b exp=%b", blank_ok, 1'b1); end
        total++; if (!hs_ok) begin bad++; $display("FAIL vga_hsync_outside_pulse got=%b exp=%b", hs_ok, 1'b1); end
        total++; if (!vs_ok) begin bad++; $display("FAIL vga_vsync_top_lines got=%b exp=%b", vs_ok, 1'b1); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q;
        int n;
        wr(GPIO_OUT_A, 32'h0000_005A, 4'hF);
        wr(MTIMECMP_LO_A, 32'h0, 4'hF);
        wr(MTIMECMP_HI_A, 32'h0, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        total++; if (int_timer !== 1'b1) begin bad++; $display("FAIL mid_int_before got=%b exp=%b", int_timer, 1'b1); end
        n = 0;
        while (hsync !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
        total++; if (n >= 4000) begin bad++; $display("FAIL mid_hsync_timeout got=%0d exp=<4000", n); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (gpio_pin_out !== 8'h00) begin bad++; $display("FAIL mid_gpio got=%h exp=%h", gpio_pin_out, 8'h00); end
        total++; if ({hsync, vsync} !== 2'b11) begin bad++; $display("FAIL mid_sync got=%b exp=%b", {hsync, vsync}, 2'b11); end
        total++; if (int_timer !== 1'b0) begin bad++; $display("FAIL mid_int got=%b exp=%b", int_timer, 1'b0); end
        @(negedge clk);
        rst_n = 1'b1;
        rd(32'h0000_0010, q);
        total++; if (q !== 32'hAABB_3344) begin bad++; $display("FAIL mid_ram_kept got=%h exp=%h", q, 32'hAABB_3344); end
        rd(GPIO_OUT_A, q);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL mid_gpio_read got=%h exp=%h", q, 32'h0); end
        rd(VGA_COLOR_A, q);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL mid_color_read got=%h exp=%h", q, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_gpio();
        test_timer();
        test_mtime_carry();
        test_vga();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
